lb_decode_mux: RTL and testbench

- Parametrised LocalBus decoder and read-return arbiter for the clk_lb domain.
- Fans the host LocalBus out to NUM_SLAVES slave ports, one per 64 KB window, and gathers each slave's read data and ready back onto a single return path.
- Hosts ID, scratch, control and status registers in window 0.
- Adds a per-read timeout with an error response and a saturating timeout counter. The previous single-slave wiring had neither.

---
 rtl/lb_decode_mux.sv | 245 ++++++++++++++++++++++++
 tb/tb_lb_decode_mux.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_decode_mux.sv
// LocalBus window decoder and read-return arbiter (clk_lb domain).
// Window 0 holds local registers; windows 1..NUM_SLAVES map to slave ports.
module lb_decode_mux #(
   parameter int          NUM_SLAVES = 4,
   parameter int          RD_TIMEOUT = 256,
   parameter logic [31:0] ID_VALUE   = 32'h53554D50,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD0000
) (
   input  logic                     clk_lb,
   input  logic                     reset,
   input  logic                     lb_wr,
   input  logic                     lb_rd,
   input  logic [31:0]              lb_addr,
   input  logic [31:0]              lb_wr_d,
   output logic [31:0]              lb_rd_d,
   output logic                     lb_rd_rdy,
   output logic [NUM_SLAVES-1:0]    slv_cs,
   output logic                     slv_wr,
   output logic                     slv_rd,
   output logic [15:0]              slv_addr,
   output logic [31:0]              slv_wr_d,
   input  logic [32*NUM_SLAVES-1:0] slv_rd_d,
   input  logic [NUM_SLAVES-1:0]    slv_rd_rdy,
   output logic [31:0]              user_ctrl,
   output logic [3:0]               led_bus
);

   localparam int TW = $clog2(RD_TIMEOUT + 1);

   // Handshake: lb_wr/lb_rd are single-cycle strobes sampled on clk_lb; a read
   // is accepted only in IDLE and answered by exactly one lb_rd_rdy pulse, with
   // lb_rd_d valid in that cycle and held afterwards. Slave strobes are 1-cycle
   // registered pulses; slv_rd_rdy counts only from the selected slave in WAIT.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [3:0]            w_win;
   logic [15:0]           w_off;
   logic [NUM_SLAVES-1:0] w_win_oh;
   logic                  w_is_local;
   logic                  w_is_slave;
   logic [31:0]           w_local_val;
   logic [31:0]           w_unmap_val;
   logic                  w_sel_rdy;
   logic [31:0]           w_sel_data;
   logic                  w_busy;
   logic                  w_go_direct;
   logic                  w_go_slave;
   logic                  w_got_rdy;
   logic                  w_timeout;
   logic                  w_unused_addr;

   logic [TW-1:0]         r_timer;
   logic [NUM_SLAVES-1:0] r_rd_cs;
   logic [3:0]            r_rd_win;
   logic [31:0]           r_rd_d;
   logic [NUM_SLAVES-1:0] r_slv_cs;
   logic                  r_slv_wr;
   logic                  r_slv_rd;
   logic [15:0]           r_slv_addr;
   logic [31:0]           r_slv_wr_d;
   logic [31:0]           r_scratch;
   logic [31:0]           r_user_ctrl;
   logic [15:0]           r_to_cnt;
   logic                  r_to_seen;
   logic [3:0]            r_last_to_win;

   assign w_win         = lb_addr[19:16];
   assign w_off         = lb_addr[15:0];
   assign w_unused_addr = ^lb_addr[31:20];
   assign w_is_local    = (w_win == 4'd0);
   assign w_is_slave    = |w_win_oh;
   assign w_unmap_val   = ERR_DATA | {28'd0, w_win};
   assign w_busy        = (r_state != ST_IDLE);

   always_comb begin
      w_win_oh = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         w_win_oh[k] = (w_win == 4'(k + 1));
      end
   end

   always_comb begin
      w_local_val = 32'd0;
      case (w_off)
         16'h0000: w_local_val = ID_VALUE;
         16'h0004: w_local_val = r_scratch;
         16'h0008: w_local_val = r_user_ctrl;
         16'h000C: w_local_val = {r_to_cnt, 11'd0, r_last_to_win, w_busy};
         default:  w_local_val = 32'd0;
      endcase
   end

   // Return path is an AND-OR mux keyed by the one-hot select latched at issue.
   always_comb begin
      w_sel_data = 32'd0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (r_rd_cs[k]) begin
            w_sel_data = w_sel_data | slv_rd_d[32*k +: 32];
         end
      end
      w_sel_rdy = |(slv_rd_rdy & r_rd_cs);
   end

   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_go_direct = 1'b0;
      w_go_slave  = 1'b0;
      w_got_rdy   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (lb_rd && !lb_wr) begin
               if (w_is_slave) begin
                  w_go_slave  = 1'b1;
                  w_state_nxt = ST_WAIT;
               end else begin
                  w_go_direct = 1'b1;
                  w_state_nxt = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (w_sel_rdy) begin
               w_got_rdy   = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (r_timer == TW'(RD_TIMEOUT)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         r_slv_cs   <= '0;
         r_slv_wr   <= 1'b0;
         r_slv_rd   <= 1'b0;
         r_slv_addr <= 16'd0;
         r_slv_wr_d <= 32'd0;
      end else begin
         r_slv_cs <= '0;
         r_slv_wr <= 1'b0;
         r_slv_rd <= 1'b0;
         if (lb_wr && w_is_slave) begin
            r_slv_cs   <= w_win_oh;
            r_slv_wr   <= 1'b1;
            r_slv_addr <= w_off;
            r_slv_wr_d <= lb_wr_d;
         end else if (w_go_slave) begin
            r_slv_cs   <= w_win_oh;
            r_slv_rd   <= 1'b1;
            r_slv_addr <= w_off;
         end
      end
   end

   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         r_timer  <= '0;
         r_rd_cs  <= '0;
         r_rd_win <= 4'd0;
      end else if (w_go_slave) begin
         r_timer  <= '0;
         r_rd_cs  <= w_win_oh;
         r_rd_win <= w_win;
      end else if (r_state == ST_WAIT) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         r_rd_d <= 32'd0;
      end else if (w_go_direct) begin
         r_rd_d <= w_is_local ? w_local_val : w_unmap_val;
      end else if (w_got_rdy) begin
         r_rd_d <= w_sel_data;
      end else if (w_timeout) begin
         r_rd_d <= ERR_DATA | {28'd0, r_rd_win};
      end
   end

   // A status write in the same cycle as a timeout leaves the counter cleared.
   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         r_scratch     <= 32'd0;
         r_user_ctrl   <= 32'd0;
         r_to_cnt      <= 16'd0;
         r_to_seen     <= 1'b0;
         r_last_to_win <= 4'd0;
      end else begin
         if (w_timeout) begin
            if (r_to_cnt != 16'hFFFF) begin
               r_to_cnt <= r_to_cnt + 16'd1;
            end
            r_to_seen     <= 1'b1;
            r_last_to_win <= r_rd_win;
         end
         if (lb_wr && w_is_local) begin
            case (w_off)
               16'h0004: r_scratch   <= lb_wr_d;
               16'h0008: r_user_ctrl <= lb_wr_d;
               16'h000C: begin
                  r_to_cnt  <= 16'd0;
                  r_to_seen <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign lb_rd_d   = r_rd_d;
   assign lb_rd_rdy = (r_state == ST_RESP);
   assign slv_cs    = r_slv_cs;
   assign slv_wr    = r_slv_wr;
   assign slv_rd    = r_slv_rd;
   assign slv_addr  = r_slv_addr;
   assign slv_wr_d  = r_slv_wr_d;
   assign user_ctrl = r_user_ctrl;
   assign led_bus   = r_user_ctrl[3:0] | {w_busy, r_to_seen, 2'b00};

endmodule

// File: tb/tb_lb_decode_mux.sv
// Bench for lb_decode_mux: vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level register/latency model.
module tb_lb_decode_mux;

   localparam int          NS  = 4;
   localparam int          T   = 256;
   localparam logic [31:0] IDV = 32'h53554D50;
   localparam logic [31:0] ERR = 32'hDEAD0000;

   logic             clk_lb;
   logic             reset;
   logic             lb_wr;
   logic             lb_rd;
   logic [31:0]      lb_addr;
   logic [31:0]      lb_wr_d;
   logic [31:0]      lb_rd_d;
   logic             lb_rd_rdy;
   logic [NS-1:0]    slv_cs;
   logic             slv_wr;
   logic             slv_rd;
   logic [15:0]      slv_addr;
   logic [31:0]      slv_wr_d;
   logic [32*NS-1:0] slv_rd_d;
   logic [NS-1:0]    slv_rd_rdy;
   logic [31:0]      user_ctrl;
   logic [3:0]       led_bus;

   lb_decode_mux #(.NUM_SLAVES(NS), .RD_TIMEOUT(T), .ID_VALUE(IDV), .ERR_DATA(ERR)) dut (
      .clk_lb(clk_lb), .reset(reset), .lb_wr(lb_wr), .lb_rd(lb_rd),
      .lb_addr(lb_addr), .lb_wr_d(lb_wr_d), .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
      .slv_cs(slv_cs), .slv_wr(slv_wr), .slv_rd(slv_rd), .slv_addr(slv_addr),
      .slv_wr_d(slv_wr_d), .slv_rd_d(slv_rd_d), .slv_rd_rdy(slv_rd_rdy),
      .user_ctrl(user_ctrl), .led_bus(led_bus)
   );

   // clock / reset
   initial clk_lb = 1'b0;
   always #5 clk_lb = ~clk_lb;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   int total = 0;
   int bad   = 0;

   // scoreboard
   logic [31:0] exp_q[$];
   int          cyc_q[$];

   // reference model state
   logic [31:0] m_scratch;
   logic [31:0] m_ctrl;
   int          m_to_cnt;
   logic        m_to_seen;
   logic [3:0]  m_last_win;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_lb);
      #1;
   endtask

   task automatic model_reset();
      m_scratch  = 0;
      m_ctrl     = 0;
      m_to_cnt   = 0;
      m_to_seen  = 0;
      m_last_win = 0;
   endtask

   function automatic logic [31:0] model_local(input logic [15:0] off);
      case (off)
         16'h0000: return IDV;
         16'h0004: return m_scratch;
         16'h0008: return m_ctrl;
         16'h000C: return {16'(m_to_cnt), 11'd0, m_last_win, 1'b0};
         default:  return 32'd0;
      endcase
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      if (a[19:16] == 4'd0) begin
         case (a[15:0])
            16'h0004: m_scratch = d;
            16'h0008: m_ctrl    = d;
            16'h000C: begin m_to_cnt = 0; m_to_seen = 0; end
            default: ;
         endcase
      end
   endtask

   // Slave ready lat cycles after slv_rd is accepted iff lat <= T; else timeout.
   task automatic model_read(input logic [31:0] a, input int lat, input logic [31:0] sd,
                             output logic [31:0] ed, output int ec);
      int w;
      w = int'(a[19:16]);
      if (w == 0) begin
         ed = model_local(a[15:0]); ec = 1;
      end else if (w > NS) begin
         ed = ERR | 32'(w); ec = 1;
      end else if (lat >= 0 && lat <= T) begin
         ed = sd; ec = lat + 2;
      end else begin
         ed = ERR | 32'(w); ec = T + 2;
         if (m_to_cnt < 65535) m_to_cnt++;
         m_to_seen  = 1'b1;
         m_last_win = 4'(w);
      end
   endtask

   // driver tasks
   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           output logic wr, output logic [3:0] cs,
                           output logic [15:0] sa, output logic [31:0] wd);
      lb_addr = a; lb_wr_d = d; lb_wr = 1'b1;
      tick();
      lb_wr = 1'b0;
      wr = slv_wr; cs = slv_cs; sa = slv_addr; wd = slv_wr_d;
   endtask

   task automatic do_read(input logic [31:0] a, input int lat, input logic [31:0] sd,
                          output logic [31:0] rdata, output int rcyc, output int nrdy,
                          output int nslv, output logic [3:0] cs, output logic [15:0] sa);
      int w;
      int c;
      w = int'(a[19:16]);
      rdata = 0; rcyc = -1; nrdy = 0; nslv = 0; cs = 0; sa = 0;
      lb_addr = a; lb_rd = 1'b1;
      tick();
      lb_rd = 1'b0;
      c = 1;
      while (c <= T + 8 && !(rcyc >= 0 && c > rcyc + 2)) begin
         slv_rd_rdy = '0;
         if (w >= 1 && w <= NS && lat >= 0 && c == 1 + lat) begin
            slv_rd_rdy[w-1] = 1'b1;
            slv_rd_d[32*(w-1) +: 32] = sd;
         end
         if (slv_rd) begin nslv++; cs = slv_cs; sa = slv_addr; end
         if (lb_rd_rdy) begin
            nrdy++;
            if (rcyc < 0) begin rcyc = c; rdata = lb_rd_d; end
         end
         tick();
         c++;
      end
      slv_rd_rdy = '0;
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      logic [31:0] exp_d;
      int          exp_cyc;
      int          exp_slv;
      logic [3:0]  exp_cs;
      logic [15:0] exp_sa;
   } vec_t;

   vec_t vecs[18];

   initial begin
      logic [31:0] rdata, wd, ed;
      logic [3:0]  cs;
      logic [15:0] sa;
      logic        wr;
      int rcyc, nrdy, nslv, ec, pulses, pc;
      logic [31:0] pd;

      vecs[0]  = '{1'b0, 32'h00000000, 32'h0,        -1,  IDV,          1,     0, 4'h0, 16'h0000};
      vecs[1]  = '{1'b1, 32'h00000004, 32'hA5A51234, -1,  32'h0,        0,     0, 4'h0, 16'h0000};
      vecs[2]  = '{1'b0, 32'h00000004, 32'h0,        -1,  32'hA5A51234, 1,     0, 4'h0, 16'h0000};
      vecs[3]  = '{1'b1, 32'h00000008, 32'h00000005, -1,  32'h0,        0,     0, 4'h0, 16'h0000};
      vecs[4]  = '{1'b0, 32'h00000008, 32'h0,        -1,  32'h00000005, 1,     0, 4'h0, 16'h0000};
      vecs[5]  = '{1'b1, 32'h00000010, 32'hFFFFFFFF, -1,  32'h0,        0,     0, 4'h0, 16'h0000};
      vecs[6]  = '{1'b0, 32'h00000010, 32'h0,        -1,  32'h00000000, 1,     0, 4'h0, 16'h0000};
      vecs[7]  = '{1'b1, 32'h00030100, 32'h0000ABCD, -1,  32'h0,        0,     1, 4'h4, 16'h0100};
      vecs[8]  = '{1'b0, 32'h00020010, 32'hCAFE0001, 5,   32'hCAFE0001, 7,     1, 4'h2, 16'h0010};
      vecs[9]  = '{1'b0, 32'h00090000, 32'h0,        -1,  32'hDEAD0009, 1,     0, 4'h0, 16'h0000};
      vecs[10] = '{1'b0, 32'h00050000, 32'h0,        -1,  32'hDEAD0005, 1,     0, 4'h0, 16'h0000};
      vecs[11] = '{1'b0, 32'h00010004, 32'h11112222, 0,   32'h11112222, 2,     1, 4'h1, 16'h0004};
      vecs[12] = '{1'b0, 32'h00040000, 32'h44440256, 256, 32'h44440256, 258,   1, 4'h8, 16'h0000};
      vecs[13] = '{1'b0, 32'h00030000, 32'h0,        -1,  32'hDEAD0003, 258,   1, 4'h4, 16'h0000};
      vecs[14] = '{1'b0, 32'h0000000C, 32'h0,        -1,  32'h00010006, 1,     0, 4'h0, 16'h0000};
      vecs[15] = '{1'b1, 32'h0000000C, 32'h0,        -1,  32'h0,        0,     0, 4'h0, 16'h0000};
      vecs[16] = '{1'b0, 32'h0000000C, 32'h0,        -1,  32'h00000006, 1,     0, 4'h0, 16'h0000};
      vecs[17] = '{1'b0, 32'h000F0000, 32'h0,        -1,  32'hDEAD000F, 1,     0, 4'h0, 16'h0000};

      reset = 1'b1; lb_wr = 0; lb_rd = 0; lb_addr = 0; lb_wr_d = 0;
      slv_rd_d = '0; slv_rd_rdy = '0;
      model_reset();
      repeat (3) tick();
      chk("rst_rd_rdy", 32'(lb_rd_rdy), 32'd0);
      chk("rst_rd_d", lb_rd_d, 32'd0);
      chk("rst_slv", {slv_cs, slv_wr, slv_rd, slv_addr}, 32'd0);
      chk("rst_ctrl_led", {user_ctrl[27:0], led_bus}, 32'd0);
      reset = 1'b0;
      tick();

      // vector table
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].is_wr) begin
            model_write(vecs[i].addr, vecs[i].data);
            do_write(vecs[i].addr, vecs[i].data, wr, cs, sa, wd);
            chk($sformatf("vec%0d_slv_wr", i), 32'(wr), 32'(vecs[i].exp_slv));
            if (vecs[i].exp_slv != 0) begin
               chk($sformatf("vec%0d_cs", i), 32'(cs), 32'(vecs[i].exp_cs));
               chk($sformatf("vec%0d_sa", i), 32'(sa), 32'(vecs[i].exp_sa));
               chk($sformatf("vec%0d_wd", i), wd, vecs[i].data);
            end
         end else begin
            model_read(vecs[i].addr, vecs[i].lat, vecs[i].data, ed, ec);
            do_read(vecs[i].addr, vecs[i].lat, vecs[i].data, rdata, rcyc, nrdy, nslv, cs, sa);
            chk($sformatf("vec%0d_data", i), rdata, vecs[i].exp_d);
            chk($sformatf("vec%0d_cyc", i), 32'(rcyc), 32'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d_npulse", i), 32'(nrdy), 32'd1);
            chk($sformatf("vec%0d_nslvrd", i), 32'(nslv), 32'(vecs[i].exp_slv));
            if (vecs[i].exp_slv != 0) begin
               chk($sformatf("vec%0d_cs", i), 32'(cs), 32'(vecs[i].exp_cs));
               chk($sformatf("vec%0d_sa", i), 32'(sa), 32'(vecs[i].exp_sa));
            end
         end
      end

      // slave write pulse lasts one cycle; unmapped write dropped
      do_write(32'h00020040, 32'h12345678, wr, cs, sa, wd);
      chk("swr_pulse", {27'd0, wr, cs}, {27'd0, 1'b1, 4'b0010});
      chk("swr_addr", 32'(sa), 32'h0040);
      chk("swr_data", wd, 32'h12345678);
      tick();
      chk("swr_end", {27'd0, slv_wr, slv_cs}, 32'd0);
      do_write(32'h00070000, 32'h0BADF00D, wr, cs, sa, wd);
      chk("swr_unmapped", {27'd0, wr, cs}, 32'd0);

      // stray ready in IDLE
      pulses = 0;
      slv_rd_rdy[0] = 1'b1; slv_rd_d[31:0] = 32'h77777777;
      for (int c = 0; c < 4; c++) begin
         if (lb_rd_rdy) pulses++;
         tick();
         slv_rd_rdy = '0;
      end
      chk("stray_rdy", 32'(pulses), 32'd0);

      // led/busy, ignored read and performed write while busy, wrong-slave ready
      chk("led_idle", 32'(led_bus), 32'(m_ctrl[3:0] | {1'b0, m_to_seen, 2'b00}));
      chk("led_idle_plan", 32'(led_bus), 32'b0101);
      lb_addr = 32'h00010000; lb_rd = 1'b1;
      tick();
      lb_rd = 1'b0;
      tick();
      chk("led_busy", 32'(led_bus), 32'(m_ctrl[3:0] | {1'b1, m_to_seen, 2'b00}));
      pulses = 0; pc = -1; pd = 0;
      for (int c = 2; c < 10; c++) begin
         if (lb_rd_rdy) begin pulses++; if (pc < 0) begin pc = c; pd = lb_rd_d; end end
         slv_rd_rdy = '0; lb_rd = 1'b0; lb_wr = 1'b0;
         case (c)
            2: begin
               slv_rd_rdy[2] = 1'b1; slv_rd_d[95:64] = 32'h99999999;
               lb_addr = 32'h00000000; lb_rd = 1'b1;
            end
            3: begin lb_addr = 32'h00000004; lb_wr_d = 32'hBEEF0001; lb_wr = 1'b1; end
            4: begin slv_rd_rdy[0] = 1'b1; slv_rd_d[31:0] = 32'h5A5A0000; end
            default: ;
         endcase
         tick();
      end
      slv_rd_rdy = '0; lb_rd = 1'b0; lb_wr = 1'b0;
      model_write(32'h00000004, 32'hBEEF0001);
      chk("busy_npulse", 32'(pulses), 32'd1);
      chk("busy_cyc", 32'(pc), 32'd5);
      chk("busy_data", pd, 32'h5A5A0000);
      model_read(32'h00000004, -1, 0, ed, ec);
      do_read(32'h00000004, -1, 0, rdata, rcyc, nrdy, nslv, cs, sa);
      chk("busy_wr_done", rdata, ed);

      // simultaneous write and read: write wins, no response
      lb_addr = 32'h00000004; lb_wr_d = 32'h00000077; lb_wr = 1'b1; lb_rd = 1'b1;
      tick();
      lb_wr = 1'b0; lb_rd = 1'b0;
      model_write(32'h00000004, 32'h00000077);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (lb_rd_rdy) pulses++;
         tick();
      end
      chk("wrrd_npulse", 32'(pulses), 32'd0);
      model_read(32'h00000004, -1, 0, ed, ec);
      do_read(32'h00000004, -1, 0, rdata, rcyc, nrdy, nslv, cs, sa);
      chk("wrrd_data", rdata, ed);

      // randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         int op, w, lat, r;
         logic [15:0] off;
         logic [31:0] a, d;
         op = $urandom_range(0, 5);
         d  = $urandom;
         case ($urandom_range(0, 5))
            0: off = 16'h0000;
            1: off = 16'h0004;
            2: off = 16'h0008;
            3: off = 16'h000C;
            4: off = 16'h0010;
            default: off = 16'($urandom);
         endcase
         if (op == 0) begin
            a = {12'($urandom), 4'd0, off};
            model_write(a, d);
            do_write(a, d, wr, cs, sa, wd);
            chk($sformatf("rnd%0d_lwr", n), 32'(wr), 32'd0);
         end else if (op == 1) begin
            w = $urandom_range(1, NS);
            a = {12'($urandom), 4'(w), 16'($urandom)};
            do_write(a, d, wr, cs, sa, wd);
            chk($sformatf("rnd%0d_swr", n), {27'd0, wr, cs}, {27'd0, 1'b1, 4'(1 << (w - 1))});
            chk($sformatf("rnd%0d_swd", n), {sa, wd[15:0]}, {a[15:0], d[15:0]});
         end else begin
            lat = -1;
            if (op == 2) begin
               a = {12'($urandom), 4'd0, off};
            end else if (op == 5) begin
               w = $urandom_range(NS + 1, 15);
               a = {12'($urandom), 4'(w), 16'($urandom)};
            end else begin
               w = $urandom_range(1, NS);
               a = {12'($urandom), 4'(w), 16'($urandom)};
               r = $urandom_range(0, 9);
               if (r == 0) lat = $urandom_range(250, 262);
               else if (r == 1) lat = -1;
               else lat = $urandom_range(0, 20);
            end
            model_read(a, lat, d, ed, ec);
            exp_q.push_back(ed);
            cyc_q.push_back(ec);
            do_read(a, lat, d, rdata, rcyc, nrdy, nslv, cs, sa);
            chk($sformatf("rnd%0d_data", n), rdata, exp_q.pop_front());
            chk($sformatf("rnd%0d_cyc", n), 32'(rcyc), 32'(cyc_q.pop_front()));
            chk($sformatf("rnd%0d_npulse", n), 32'(nrdy), 32'd1);
            if (op == 3 || op == 4)
               chk($sformatf("rnd%0d_slvrd", n), {nslv[3:0], cs}, {4'd1, 4'(1 << (w - 1))});
            else
               chk($sformatf("rnd%0d_slvrd", n), 32'(nslv), 32'd0);
         end
      end
      model_read(32'h0000000C, -1, 0, ed, ec);
      do_read(32'h0000000C, -1, 0, rdata, rcyc, nrdy, nslv, cs, sa);
      chk("rnd_status", rdata, ed);

      // reset in the middle of a slave read
      lb_addr = 32'h00030000; lb_rd = 1'b1;
      tick();
      lb_rd = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_rdy", 32'(lb_rd_rdy), 32'd0);
      chk("midrst_outs", {slv_cs, slv_wr, slv_rd, led_bus}, 32'd0);
      chk("midrst_data", lb_rd_d | user_ctrl, 32'd0);
      tick();
      reset = 1'b0;
      model_reset();
      pulses = 0;
      slv_rd_rdy[2] = 1'b1; slv_rd_d[95:64] = 32'h3333AAAA;
      for (int c = 0; c < 5; c++) begin
         if (lb_rd_rdy) pulses++;
         tick();
         slv_rd_rdy = '0;
      end
      chk("midrst_late_rdy", 32'(pulses), 32'd0);
      model_read(32'h00000004, -1, 0, ed, ec);
      do_read(32'h00000004, -1, 0, rdata, rcyc, nrdy, nslv, cs, sa);
      chk("midrst_scratch", rdata, ed);
      chk("midrst_scratch_cyc", 32'(rcyc), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
